// File: rtl/seven_seg_scan_controller.sv
// seven_seg_scan_controller
//
// Time-multiplexed driver for a four-digit, common-anode seven-segment
// display. Each digit gets a slot of REFRESH_DIV clock cycles. The first GUARD
// cycles of every slot keep all anodes off, so the previous digit's segments
// never ghost onto the next digit. Display data is double buffered. A load
// lands in a shadow register and is promoted to the active register only at a
// frame boundary, so a frame never mixes old and new digits.
//
// Parameters
//   REFRESH_DIV : clock cycles per digit slot (4 .. 2^20)
//   GUARD       : blanking cycles at the start of each slot (1 .. REFRESH_DIV-2)
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   en         : scan enable; low darkens the display and holds the scan at rest
//   load       : one-cycle strobe capturing data_in / blank_in
//   data_in    : four hex nibbles, [3:0] = digit 0 (rightmost)
//   blank_in   : per-digit blank mask, bit i blanks digit i
//   seg        : segment cathodes {g,f,e,d,c,b,a}, active-low, registered
//   an         : digit anodes, active-low, registered, at most one bit low
//   frame_tick : one-cycle pulse in the last cycle of the digit-3 slot
//   pending    : shadow data is waiting for the next frame boundary

module seven_seg_scan_controller #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [3:0]  blank_in,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_tick,
    output logic        pending
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST_CNT  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_CNT = CW'(GUARD);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   slot_cnt;
    logic [CW-1:0]   next_cnt;
    logic [1:0]      digit_idx;
    logic [1:0]      next_idx;
    logic [15:0]     active_data;
    logic [15:0]     next_active_data;
    logic [3:0]      active_blank;
    logic [3:0]      next_active_blank;
    logic [15:0]     shadow_data;
    logic [15:0]     next_shadow_data;
    logic [3:0]      shadow_blank;
    logic [3:0]      next_shadow_blank;
    logic            next_pending;
    logic            boundary;
    logic [3:0]      nibble;
    logic [6:0]      next_seg;
    logic [3:0]      next_an;
    logic            next_tick;

    // Active-low hex decode in {g,f,e,d,c,b,a} order.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pattern;
        case (nib)
            4'h0:    pattern = 7'b1000000;
            4'h1:    pattern = 7'b1111001;
            4'h2:    pattern = 7'b0100100;
            4'h3:    pattern = 7'b0110000;
            4'h4:    pattern = 7'b0011001;
            4'h5:    pattern = 7'b0010010;
            4'h6:    pattern = 7'b0000010;
            4'h7:    pattern = 7'b1111000;
            4'h8:    pattern = 7'b0000000;
            4'h9:    pattern = 7'b0010000;
            4'hA:    pattern = 7'b0001000;
            4'hB:    pattern = 7'b0000011;
            4'hC:    pattern = 7'b1000110;
            4'hD:    pattern = 7'b0100001;
            4'hE:    pattern = 7'b0000110;
            default: pattern = 7'b0001110;
        endcase
        return pattern;
    endfunction

    // A frame boundary is the wrap out of the last digit-3 cycle. It only
    // counts while scanning continues. If en drops in that same cycle the scan
    // stops and nothing is promoted.
    assign boundary = (state == SCAN) && en && (slot_cnt == LAST_CNT) && (digit_idx == 2'd3);

    // Scan sequencing. IDLE parks the counter and index at zero, so every
    // entry into SCAN starts at digit 0, counter 0. Inside SCAN the counter
    // wraps each slot and the digit index walks 0..3.
    always_comb begin
        next_state = state;
        next_cnt   = slot_cnt;
        next_idx   = digit_idx;
        case (state)
            IDLE: begin
                next_cnt = '0;
                next_idx = 2'd0;
                if (en) begin
                    next_state = SCAN;
                end
            end
            SCAN: begin
                if (!en) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                    next_idx   = 2'd0;
                end else if (slot_cnt == LAST_CNT) begin
                    next_cnt = '0;
                    next_idx = digit_idx + 2'd1;
                end else begin
                    next_cnt = slot_cnt + 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Double buffering. While nothing is displayed (IDLE), or when a load
    // coincides with a frame boundary, data goes straight to the active
    // register. Otherwise a load parks in the shadow and raises pending. A
    // later load overwrites the shadow, so the last load wins. A pending
    // shadow is promoted at the next boundary or on re-entry to SCAN.
    always_comb begin
        next_active_data  = active_data;
        next_active_blank = active_blank;
        next_shadow_data  = shadow_data;
        next_shadow_blank = shadow_blank;
        next_pending      = pending;
        if (load) begin
            next_shadow_data  = data_in;
            next_shadow_blank = blank_in;
        end
        if ((state == IDLE) || boundary) begin
            if (load) begin
                next_active_data  = data_in;
                next_active_blank = blank_in;
                next_pending      = 1'b0;
            end else if (pending && (boundary || en)) begin
                next_active_data  = shadow_data;
                next_active_blank = shadow_blank;
                next_pending      = 1'b0;
            end
        end else if (load) begin
            next_pending = 1'b1;
        end
    end

    // Output decode is computed from next-cycle values and then registered.
    // This keeps seg/an free of input-to-output paths and keeps them aligned
    // with the slot counter they describe. Segments are dark whenever the
    // anodes are, which covers the guard window and blanked digits.
    always_comb begin
        nibble    = next_active_data[{next_idx, 2'b00} +: 4];
        next_an   = 4'b1111;
        next_seg  = 7'b1111111;
        next_tick = 1'b0;
        if (next_state == SCAN) begin
            if ((next_cnt >= GUARD_CNT) && !next_active_blank[next_idx]) begin
                next_an  = ~(4'b0001 << next_idx);
                next_seg = hex_to_seg(nibble);
            end
            next_tick = (next_cnt == LAST_CNT) && (next_idx == 2'd3);
        end
    end

    // State, buffers and registered outputs. Reset forces everything dark and
    // clears both buffers, regardless of en and load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            slot_cnt     <= '0;
            digit_idx    <= 2'd0;
            active_data  <= 16'h0000;
            active_blank <= 4'b0000;
            shadow_data  <= 16'h0000;
            shadow_blank <= 4'b0000;
            pending      <= 1'b0;
            seg          <= 7'b1111111;
            an           <= 4'b1111;
            frame_tick   <= 1'b0;
        end else begin
            state        <= next_state;
            slot_cnt     <= next_cnt;
            digit_idx    <= next_idx;
            active_data  <= next_active_data;
            active_blank <= next_active_blank;
            shadow_data  <= next_shadow_data;
            shadow_blank <= next_shadow_blank;
            pending      <= next_pending;
            seg          <= next_seg;
            an           <= next_an;
            frame_tick   <= next_tick;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// tb_seven_seg_scan_controller
//
// Directed bench for seven_seg_scan_controller with REFRESH_DIV=8, GUARD=2.
// Inputs are driven and outputs are sampled on the falling edge. Expected
// values come from a hex table written out by hand and a small model of
// which data is on display.

module tb_seven_seg_scan_controller;

    localparam int REFRESH_DIV = 8;
    localparam int GUARD       = 2;
    localparam int FRAME       = 4 * REFRESH_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  blank_in;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;
    logic        pending;

    int checks = 0;
    int errors = 0;

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic [15:0] m_shown;
    logic [3:0]  m_blank;
    logic [15:0] m_shadow;
    logic [3:0]  m_shadow_blank;
    logic        m_pending;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    seven_seg_scan_controller #(
        .REFRESH_DIV (REFRESH_DIV),
        .GUARD       (GUARD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .data_in    (data_in),
        .blank_in   (blank_in),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick),
        .pending    (pending)
    );

    // Watchdog so a stuck run still reports.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic l,
                                 input logic [15:0] d, input logic [3:0] b);
        rst      = r;
        en       = e;
        load     = l;
        data_in  = d;
        blank_in = b;
    endtask

    task automatic checkDark(input string tag, input logic exp_pending);
        checkOutput({tag, "_an"}, 32'(an), 32'h0000000F);
        checkOutput({tag, "_seg"}, 32'(seg), 32'h0000007F);
        checkOutput({tag, "_tick"}, 32'(frame_tick), 32'h0);
        checkOutput({tag, "_pending"}, 32'(pending), 32'(exp_pending));
    endtask

    // Expected display for scan cycle pos, counted from the entry into SCAN.
    task automatic checkScan(input int pos);
        int         cnt;
        int         idx;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_tick;
        cnt      = pos % REFRESH_DIV;
        idx      = (pos / REFRESH_DIV) % 4;
        exp_an   = 4'b1111;
        exp_seg  = 7'b1111111;
        exp_tick = (cnt == REFRESH_DIV - 1) && (idx == 3);
        if ((cnt >= GUARD) && !m_blank[idx]) begin
            exp_an[idx] = 1'b0;
            exp_seg     = hex_tab[m_shown[idx*4 +: 4]];
        end
        checkOutput($sformatf("an@%0d", pos), 32'(an), 32'(exp_an));
        checkOutput($sformatf("seg@%0d", pos), 32'(seg), 32'(exp_seg));
        checkOutput($sformatf("tick@%0d", pos), 32'(frame_tick), 32'(exp_tick));
        checkOutput($sformatf("pending@%0d", pos), 32'(pending), 32'(m_pending));
    endtask

    // Drive the inputs for the edge that ends scan cycle pos and update the
    // model of what will be on display after that edge.
    task automatic advanceScan(input int pos, input logic e, input logic l,
                               input logic [15:0] d, input logic [3:0] b);
        logic at_boundary;
        at_boundary = e && ((pos % FRAME) == FRAME - 1);
        if (l) begin
            if (at_boundary) begin
                m_shown   = d;
                m_blank   = b;
                m_pending = 1'b0;
            end else begin
                m_shadow       = d;
                m_shadow_blank = b;
                m_pending      = 1'b1;
            end
        end else if (at_boundary && m_pending) begin
            m_shown   = m_shadow;
            m_blank   = m_shadow_blank;
            m_pending = 1'b0;
        end
        applyStimulus(1'b0, e, l, d, b);
        @(negedge clk);
    endtask

    initial begin
        logic        e;
        logic        l;
        logic [15:0] d;
        logic [3:0]  b;

        m_shown        = 16'h0000;
        m_blank        = 4'b0000;
        m_shadow       = 16'h0000;
        m_shadow_blank = 4'b0000;
        m_pending      = 1'b0;

        // Reset held for three cycles while en and load are both high.
        applyStimulus(1'b1, 1'b1, 1'b1, 16'hFFFF, 4'hF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkDark($sformatf("reset%0d", i), 1'b0);
        end

        // Load in IDLE goes straight to the active register.
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h1234, 4'h0);
        @(negedge clk);
        checkDark("idle_load", 1'b0);
        m_shown = 16'h1234;
        m_blank = 4'b0000;

        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 4'h0);
        @(negedge clk);

        // Five frames of continuous scanning with scheduled loads, ending in
        // an enable drop during the digit-2 slot.
        for (int pos = 0; pos <= 148; pos++) begin
            checkScan(pos);
            if (pos == 10) checkOutput("digit1_three", 32'(seg), 32'h30);
            if (pos == 28) checkOutput("pending_hold", 32'(pending), 32'h1);
            if (pos == 34) checkOutput("digit0_d", 32'(seg), 32'h21);
            if (pos == 74) checkOutput("digit1_F", 32'(seg), 32'h0E);
            if (pos == 117) checkOutput("blank_digit2", 32'(an), 32'hF);
            e = 1'b1;
            l = 1'b0;
            d = 16'h0000;
            b = 4'h0;
            case (pos)
                12:  begin l = 1'b1; d = 16'hABCD; end
                63:  begin l = 1'b1; d = 16'h00F0; end
                95:  begin l = 1'b1; d = 16'h00F0; b = 4'b0100; end
                127: begin l = 1'b1; d = 16'h00F0; end
                132: begin l = 1'b1; d = 16'h5678; end
                148: e = 1'b0;
                default: ;
            endcase
            advanceScan(pos, e, l, d, b);
        end

        // Enable dropped: dark output while the shadow stays pending.
        for (int k = 0; k < 3; k++) begin
            checkDark($sformatf("en_low%0d", k), 1'b1);
            applyStimulus(1'b0, (k == 2), 1'b0, 16'h0000, 4'h0);
            @(negedge clk);
        end
        m_shown   = m_shadow;
        m_blank   = m_shadow_blank;
        m_pending = 1'b0;

        // Re-entry restarts at digit 0 showing the promoted shadow data.
        for (int pos = 0; pos < 44; pos++) begin
            checkScan(pos);
            advanceScan(pos, 1'b1, 1'b0, 16'h0000, 4'h0);
        end
        checkScan(44);

        // Reset mid-slot aborts the scan and clears the buffers.
        applyStimulus(1'b1, 1'b1, 1'b1, 16'hBEEF, 4'h0);
        @(negedge clk);
        checkDark("mid_reset", 1'b0);
        m_shown   = 16'h0000;
        m_blank   = 4'b0000;
        m_shadow  = 16'h0000;
        m_pending = 1'b0;

        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 4'h0);
        @(negedge clk);
        for (int pos = 0; pos < 12; pos++) begin
            checkScan(pos);
            advanceScan(pos, 1'b1, 1'b0, 16'h0000, 4'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
